music_sequencer: RTL and testbench

//  Sequences the square-wave note generator: walks an internal melody table one beat at a time,

---
 rtl/music_sequencer_if.sv | 27 ++
 rtl/music_sequencer.sv | 164 ++++++++++++++++
 tb/tb_music_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/music_sequencer_if.sv
// Bundle between the button/debounce side (master) and the melody sequencer (slave).
// beat_idx width is set by IDX_W and must equal clog2(NUM_BEATS) of the attached sequencer.
interface music_sequencer_if #(
  parameter int IDX_W = 6
);
  logic                play_pulse;
  logic                pause_pulse;
  logic                stop_pulse;
  logic                vol_up;
  logic                vol_down;
  logic [21:0]         note_div;
  logic signed [15:0]  volumn_max;
  logic signed [15:0]  volumn_min;
  logic [IDX_W-1:0]    beat_idx;
  logic                playing;
  logic [2:0]          vol_level;

  modport master (
    output play_pulse, pause_pulse, stop_pulse, vol_up, vol_down,
    input  note_div, volumn_max, volumn_min, beat_idx, playing, vol_level
  );

  modport slave (
    input  play_pulse, pause_pulse, stop_pulse, vol_up, vol_down,
    output note_div, volumn_max, volumn_min, beat_idx, playing, vol_level
  );
endinterface

// File: rtl/music_sequencer.sv
// Melody sequencer: play/pause/stop FSM, beat timer, melody table and 5-step volume.
// Define MUSIC_SEQ_LOOP_EN to wrap the melody forever; otherwise playback stops at the end.
module music_sequencer #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BEAT_DIV  = 25_000_000,
  parameter int NUM_BEATS = 64,
  parameter int VOL_INIT  = 3
) (
  input  logic             clk,
  input  logic             reset,
  music_sequencer_if.slave bus
);
  localparam int IDX_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;

  // Half-period divider rounded to nearest; frequencies given in centi-Hz.
  function automatic logic [21:0] calc_div(input longint f_chz);
    longint q;
    q = (longint'(CLK_HZ) * 100 + f_chz) / (2 * f_chz);
    return q[21:0];
  endfunction

  localparam logic [21:0] DIV_C4  = calc_div(longint'(26163));
  localparam logic [21:0] DIV_CS4 = calc_div(longint'(27718));
  localparam logic [21:0] DIV_D4  = calc_div(longint'(29366));
  localparam logic [21:0] DIV_DS4 = calc_div(longint'(31113));
  localparam logic [21:0] DIV_E4  = calc_div(longint'(32963));
  localparam logic [21:0] DIV_F4  = calc_div(longint'(34923));
  localparam logic [21:0] DIV_FS4 = calc_div(longint'(36999));
  localparam logic [21:0] DIV_G4  = calc_div(longint'(39200));
  localparam logic [21:0] DIV_GS4 = calc_div(longint'(41530));
  localparam logic [21:0] DIV_A4  = calc_div(longint'(44000));
  localparam logic [21:0] DIV_AS4 = calc_div(longint'(46616));
  localparam logic [21:0] DIV_B4  = calc_div(longint'(49388));

  function automatic logic [3:0] melody(input logic [IDX_W-1:0] idx);
    case (int'(idx) % 16)
      0: return 4'd1;   1: return 4'd3;   2: return 4'd5;   3: return 4'd0;
      4: return 4'd6;   5: return 4'd8;   6: return 4'd10;  7: return 4'd12;
      8: return 4'd12;  9: return 4'd10;  10: return 4'd8;  11: return 4'd6;
      12: return 4'd5;  13: return 4'd3;  14: return 4'd1;  default: return 4'd0;
    endcase
  endfunction

  function automatic logic [21:0] note_div_of(input logic [3:0] code);
    case (code)
      4'd1:  return DIV_C4;   4'd2:  return DIV_CS4;  4'd3:  return DIV_D4;
      4'd4:  return DIV_DS4;  4'd5:  return DIV_E4;   4'd6:  return DIV_F4;
      4'd7:  return DIV_FS4;  4'd8:  return DIV_G4;   4'd9:  return DIV_GS4;
      4'd10: return DIV_A4;   4'd11: return DIV_AS4;  4'd12: return DIV_B4;
      default: return 22'd1;
    endcase
  endfunction

  function automatic logic signed [15:0] amp_of(input logic [2:0] lvl);
    return signed'({1'b0, lvl, 12'h000});
  endfunction

  // Saturating 1..5 step; simultaneous up/down cancels.
  function automatic logic [2:0] vol_step(input logic [2:0] lvl, input logic up, input logic dn);
    if (up && !dn && lvl < 3'd5) return lvl + 3'd1;
    if (dn && !up && lvl > 3'd1) return lvl - 3'd1;
    return lvl;
  endfunction

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   beat_idx_q, beat_idx_d;
  logic [26:0]        cnt_q, cnt_d;
  logic [2:0]         vol_q, vol_d;
  logic [21:0]        note_div_q, note_div_d;
  logic signed [15:0] vmax_q, vmax_d;
  logic signed [15:0] vmin_q, vmin_d;
  logic [3:0]         code;

  assign code = melody(beat_idx_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      beat_idx_q <= '0;
      cnt_q      <= '0;
      vol_q      <= 3'(VOL_INIT);
      note_div_q <= 22'd1;
      vmax_q     <= '0;
      vmin_q     <= '0;
    end else begin
      state_q    <= state_d;
      beat_idx_q <= beat_idx_d;
      cnt_q      <= cnt_d;
      vol_q      <= vol_d;
      note_div_q <= note_div_d;
      vmax_q     <= vmax_d;
      vmin_q     <= vmin_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_idx_d = beat_idx_q;
    cnt_d      = cnt_q;
    vol_d      = vol_step(vol_q, bus.vol_up, bus.vol_down);
    case (state_q)
      IDLE: begin
        if (!bus.stop_pulse && !bus.pause_pulse && bus.play_pulse) begin
          state_d = PLAY;
          cnt_d   = '0;
        end
      end
      PLAY: begin
        if (bus.stop_pulse) begin
          state_d    = IDLE;
          beat_idx_d = '0;
          cnt_d      = '0;
        end else if (bus.pause_pulse) begin
          state_d = PAUSE;
        end else if (cnt_q == 27'(BEAT_DIV - 1)) begin
          cnt_d = '0;
          if (beat_idx_q == IDX_W'(NUM_BEATS - 1)) begin
            beat_idx_d = '0;
`ifdef MUSIC_SEQ_LOOP_EN
            state_d = PLAY;
`else
            state_d = IDLE;
`endif
          end else begin
            beat_idx_d = beat_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 27'd1;
        end
      end
      PAUSE: begin
        if (bus.stop_pulse) begin
          state_d    = IDLE;
          beat_idx_d = '0;
          cnt_d      = '0;
        end else if (!bus.pause_pulse && bus.play_pulse) begin
          state_d = PLAY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // note_div keeps its last value when silent so the tone generator never glitches.
  always_comb begin
    note_div_d = note_div_q;
    vmax_d     = '0;
    vmin_d     = '0;
    if (state_q == PLAY && code != 4'd0) begin
      note_div_d = note_div_of(code);
      vmax_d     = amp_of(vol_q);
      vmin_d     = -amp_of(vol_q);
    end
  end

  assign bus.note_div   = note_div_q;
  assign bus.volumn_max = vmax_q;
  assign bus.volumn_min = vmin_q;
  assign bus.beat_idx   = beat_idx_q;
  assign bus.playing    = (state_q == PLAY);
  assign bus.vol_level  = vol_q;
endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer with BEAT_DIV=4, NUM_BEATS=8 (melody C4 D4 E4 rest F4 G4 A4 B4).
module tb_music_sequencer;
  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  music_sequencer_if #(.IDX_W(3)) bus ();

  music_sequencer #(
    .CLK_HZ(100_000_000), .BEAT_DIV(4), .NUM_BEATS(8), .VOL_INIT(3)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idx(input int target, input string tag);
    int n;
    n = 0;
    while (32'(bus.beat_idx) != target && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.beat_idx), 32'(target));
  endtask

  initial begin
    reset = 1'b0;
    bus.play_pulse = 0; bus.pause_pulse = 0; bus.stop_pulse = 0;
    bus.vol_up = 0; bus.vol_down = 0;
    repeat (3) tick();
    chk("rst_idx",   32'(bus.beat_idx), 32'd0);
    chk("rst_play",  32'(bus.playing), 32'd0);
    chk("rst_div",   32'(bus.note_div), 32'd1);
    chk("rst_vmax",  {16'h0, bus.volumn_max}, 32'h0);
    chk("rst_vol",   32'(bus.vol_level), 32'd3);
    reset = 1'b1;
    tick();

    // play from IDLE, beat 0 = C4
    bus.play_pulse = 1; tick(); bus.play_pulse = 0;
    chk("play_on",   32'(bus.playing), 32'd1);
    chk("play_vmax0", {16'h0, bus.volumn_max}, 32'h0);
    tick();
    chk("c4_div",    32'(bus.note_div), 32'd191110);
    chk("c4_vmax",   {16'h0, bus.volumn_max}, 32'h3000);
    chk("c4_vmin",   {16'h0, bus.volumn_min}, 32'hD000);
    tick(); tick();
    chk("beat0_hold", 32'(bus.beat_idx), 32'd0);
    tick();
    chk("beat1",     32'(bus.beat_idx), 32'd1);
    tick();
    chk("d4_div",    32'(bus.note_div), 32'd170265);

    // pause at beat 2 count 1
    repeat (4) tick();
    bus.pause_pulse = 1; tick(); bus.pause_pulse = 0;
    chk("pause_play", 32'(bus.playing), 32'd0);
    tick();
    chk("pause_vmax", {16'h0, bus.volumn_max}, 32'h0);
    chk("pause_div",  32'(bus.note_div), 32'd151685);
    repeat (18) tick();
    chk("pause_idx",  32'(bus.beat_idx), 32'd2);
    bus.play_pulse = 1; tick(); bus.play_pulse = 0;
    chk("resume_play", 32'(bus.playing), 32'd1);
    tick(); tick();
    chk("resume_idx2", 32'(bus.beat_idx), 32'd2);
    tick();
    chk("resume_idx3", 32'(bus.beat_idx), 32'd3);
    tick();
    chk("rest_vmax",  {16'h0, bus.volumn_max}, 32'h0);
    chk("rest_vmin",  {16'h0, bus.volumn_min}, 32'h0);

    // stop + pause + play together: stop wins
    bus.stop_pulse = 1; bus.pause_pulse = 1; bus.play_pulse = 1; tick();
    bus.stop_pulse = 0; bus.pause_pulse = 0; bus.play_pulse = 0;
    chk("stop_play",  32'(bus.playing), 32'd0);
    chk("stop_idx",   32'(bus.beat_idx), 32'd0);
    tick();
    chk("stop_vmax",  {16'h0, bus.volumn_max}, 32'h0);

    // volume saturation while playing
    bus.play_pulse = 1; tick(); bus.play_pulse = 0;
    bus.vol_up = 1; repeat (4) tick(); bus.vol_up = 0;
    chk("vol_max",    32'(bus.vol_level), 32'd5);
    tick();
    chk("vol5_vmax",  {16'h0, bus.volumn_max}, 32'h5000);
    bus.vol_down = 1; repeat (6) tick(); bus.vol_down = 0;
    chk("vol_min",    32'(bus.vol_level), 32'd1);
    tick();
    chk("vol1_vmax",  {16'h0, bus.volumn_max}, 32'h1000);
    chk("vol1_vmin",  {16'h0, bus.volumn_min}, 32'hF000);
    bus.vol_up = 1; bus.vol_down = 1; tick(); bus.vol_up = 0; bus.vol_down = 0;
    chk("vol_both",   32'(bus.vol_level), 32'd1);

    // end of melody
    wait_idx(7, "reach_beat7");
    repeat (3) tick();
    chk("beat7_hold", 32'(bus.beat_idx), 32'd7);
    tick();
    chk("end_idx",    32'(bus.beat_idx), 32'd0);
`ifdef MUSIC_SEQ_LOOP_EN
    chk("end_play",   32'(bus.playing), 32'd1);
    tick();
    chk("end_vmax",   {16'h0, bus.volumn_max}, 32'h1000);
`else
    chk("end_play",   32'(bus.playing), 32'd0);
    tick();
    chk("end_vmax",   {16'h0, bus.volumn_max}, 32'h0);
`endif

    // async reset mid-playback at beat 5
    bus.play_pulse = 1; tick(); bus.play_pulse = 0;
    wait_idx(5, "reach_beat5");
    tick();
    chk("b5_play",    32'(bus.playing), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_idx",   32'(bus.beat_idx), 32'd0);
    chk("arst_play",  32'(bus.playing), 32'd0);
    chk("arst_vmax",  {16'h0, bus.volumn_max}, 32'h0);
    chk("arst_div",   32'(bus.note_div), 32'd1);
    chk("arst_vol",   32'(bus.vol_level), 32'd3);
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst",   32'(bus.playing), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
